// File: rtl/rename_pkg.sv
// rename_pkg: register-rename sizing and types shared by the free list and the RAT.
package rename_pkg;
    localparam int ARCH_REGS = 35;
    localparam int PHYS_REGS = 64;
    localparam int LOG_PHYS  = $clog2(PHYS_REGS);
    typedef logic [LOG_PHYS-1:0] preg_t;
endpackage

// File: rtl/free_list_if.sv
// free_list_if: allocate/free handshake and status between the renamer/retire logic and the free list.
interface free_list_if import rename_pkg::*; #(
    parameter int NUM_ARCH_REGS = ARCH_REGS,
    parameter int NUM_PHYS_REGS = PHYS_REGS
);
    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    logic                             Alloc_req;
    logic                             Alloc_valid;
    logic [$clog2(NUM_PHYS_REGS)-1:0] Alloc_preg;
    logic                             Free_valid;
    logic [$clog2(NUM_PHYS_REGS)-1:0] Free_preg;
    logic [$clog2(DEPTH+1)-1:0]       Free_count;
    logic                             Empty;
    logic                             Full;
    logic                             Error;
    modport master (
        output Alloc_req, Free_valid, Free_preg,
        input  Alloc_valid, Alloc_preg, Free_count, Empty, Full, Error
    );
    modport slave (
        input  Alloc_req, Free_valid, Free_preg,
        output Alloc_valid, Alloc_preg, Free_count, Empty, Full, Error
    );
endinterface

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical registers with show-ahead grant; define FREE_LIST_BYPASS_EN to hand a freed register straight to an empty-list allocation.
module free_list import rename_pkg::*; #(
    parameter int NUM_ARCH_REGS = ARCH_REGS,
    parameter int NUM_PHYS_REGS = PHYS_REGS
) (
    input logic        CLK,
    input logic        RESET,
    free_list_if.slave fl
);
    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int PW    = $clog2(NUM_PHYS_REGS);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          error;
    logic          empty, full, byp, pop, push, drop;

    // Status comes only from the registered count; pop/push/drop decide this cycle's update.
    always_comb begin
        empty = count == '0;
        full  = count == CW'(DEPTH);
`ifdef FREE_LIST_BYPASS_EN
        byp   = empty && fl.Free_valid;
`else
        byp   = 1'b0;
`endif
        pop   = fl.Alloc_req && !empty;
        push  = fl.Free_valid && (!full || pop) && !(byp && fl.Alloc_req);
        drop  = fl.Free_valid && full && !pop;
    end

    // Head of the list is offered immediately; bypass substitutes the incoming register when empty.
    always_comb begin
        fl.Alloc_valid = !empty || byp;
        fl.Alloc_preg  = byp ? fl.Free_preg : mem[head];
        fl.Free_count  = count;
        fl.Empty       = empty;
        fl.Full        = full;
        fl.Error       = error;
    end

    // Reset refills the list with every non-architectural register; otherwise apply pop, push and overflow.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= PW'(NUM_ARCH_REGS + i);
            head  <= '0;
            tail  <= '0;
            count <= CW'(DEPTH);
            error <= 1'b0;
        end else begin
            if (push) mem[tail] <= fl.Free_preg;
            if (pop) head <= (head == AW'(DEPTH - 1)) ? '0 : head + 1'b1;
            if (push) tail <= (tail == AW'(DEPTH - 1)) ? '0 : tail + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (drop) error <= 1'b1;
        end
    end
endmodule
